// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// The result is computed when the operation is accepted and held back until the latency counter expires.
module mul_div_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] pend_hi;
    logic [WIDTH-1:0] pend_lo;
    logic             pend_valid;

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic               div_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   div_b;
    logic [WIDTH-1:0]   uq;
    logic [WIDTH-1:0]   ur;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               res_valid;

    assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Signed division runs on magnitudes so INT_MIN / -1 wraps to INT_MIN with remainder 0.
    assign div_signed = (op == OP_DIV);
    assign a_neg      = div_signed & a[WIDTH-1];
    assign b_neg      = div_signed & b[WIDTH-1];
    assign abs_a      = a_neg ? (~a + 1'b1) : a;
    assign abs_b      = b_neg ? (~b + 1'b1) : b;
    assign div_b      = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : abs_b;
    assign uq         = abs_a / div_b;
    assign ur         = abs_a % div_b;
    assign quo        = (a_neg ^ b_neg) ? (~uq + 1'b1) : uq;
    assign rem        = a_neg ? (~ur + 1'b1) : ur;

    always_comb begin
        res_hi    = '0;
        res_lo    = '0;
        res_valid = 1'b0;
        case (op)
            OP_MULT: begin
                res_hi    = prod_s[2*WIDTH-1:WIDTH];
                res_lo    = prod_s[WIDTH-1:0];
                res_valid = 1'b1;
            end
            OP_MULTU: begin
                res_hi    = prod_u[2*WIDTH-1:WIDTH];
                res_lo    = prod_u[WIDTH-1:0];
                res_valid = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                res_hi    = rem;
                res_lo    = quo;
                res_valid = (b != '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            busy       <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            pend_hi    <= '0;
            pend_lo    <= '0;
            pend_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                pend_hi    <= res_hi;
                                pend_lo    <= res_lo;
                                pend_valid <= res_valid;
                                count      <= (op[1]) ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                                busy       <= 1'b1;
                                state      <= BUSY;
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    if (flush) begin
                        count <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        count <= count - 1'b1;
                        if (count == CW'(1)) begin
                            if (pend_valid) begin
                                hi <= pend_hi;
                                lo <= pend_lo;
                            end
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, arithmetic corner cases, MTHI/MTLO, flush and async reset.
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks;
    int n_fail;
    int cycles;

    mul_div_unit #(.WIDTH(W), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one request for a single edge; returns at the falling edge after acceptance.
    // Operands are scrambled afterwards so a result depending on live a/b would show up.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        flush = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset = 1'b1;

        // MULT -3 * 7
        issue(3'd0, 32'hFFFFFFFD, 32'd7);
        wait_done(cycles);
        check("mult_cycles", cycles, 32'd5);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFEB);

        // DIVU 100 / 7
        issue(3'd3, 32'd100, 32'd7);
        wait_done(cycles);
        check("divu_cycles", cycles, 32'd10);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        // DIV -7 / 2
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_done(cycles);
        check("div_neg_lo", lo, 32'hFFFFFFFD);
        check("div_neg_hi", hi, 32'hFFFFFFFF);

        // DIV 7 / -2 : quotient -3, remainder +1
        issue(3'd2, 32'd7, 32'hFFFFFFFE);
        wait_done(cycles);
        check("div_negb_lo", lo, 32'hFFFFFFFD);
        check("div_negb_hi", hi, 32'd1);

        // MTLO while idle
        issue(3'd5, 32'h1234, 32'd0);
        check("mtlo_busy", {31'd0, busy}, 32'd0);
        check("mtlo_lo", lo, 32'h1234);
        check("mtlo_hi_kept", hi, 32'd1);

        // Reserved op has no effect
        issue(3'd6, 32'hAAAA5555, 32'd3);
        check("rsvd_busy", {31'd0, busy}, 32'd0);
        check("rsvd_hi", hi, 32'd1);
        check("rsvd_lo", lo, 32'h1234);

        // MTHI during a MULT busy period is ignored
        issue(3'd0, 32'd5, 32'd6);
        start = 1'b1;
        op    = 3'd4;
        a     = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0;
        wait_done(cycles);
        check("mthi_busy_cycles", cycles, 32'd4);
        check("mthi_busy_hi", hi, 32'd0);
        check("mthi_busy_lo", lo, 32'd30);

        // Preset hi/lo then divide by zero
        issue(3'd4, 32'd5, 32'd0);
        issue(3'd5, 32'd6, 32'd0);
        issue(3'd2, 32'd9, 32'd0);
        wait_done(cycles);
        check("div0_cycles", cycles, 32'd10);
        check("div0_hi", hi, 32'd5);
        check("div0_lo", lo, 32'd6);

        issue(3'd3, 32'd9, 32'd0);
        wait_done(cycles);
        check("divu0_hi", hi, 32'd5);
        check("divu0_lo", lo, 32'd6);

        // INT_MIN / -1 wraps
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_done(cycles);
        check("ovf_lo", lo, 32'h80000000);
        check("ovf_hi", hi, 32'd0);

        // Flush in busy cycle 2
        issue(3'd0, 32'd3, 32'd4);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        check("flush_hi", hi, 32'd0);
        check("flush_lo", lo, 32'h80000000);

        // Start right after flush is accepted normally
        issue(3'd0, 32'd3, 32'd4);
        wait_done(cycles);
        check("post_flush_cycles", cycles, 32'd5);
        check("post_flush_lo", lo, 32'd12);
        check("post_flush_hi", hi, 32'd0);

        // Flush beats start in the same cycle
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        op    = 3'd5;
        a     = 32'h77;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_lo", lo, 32'd12);
        check("flush_start_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-DIV
        issue(3'd2, 32'd100, 32'd3);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_busy", {31'd0, busy}, 32'd0);
        check("async_hi", hi, 32'd0);
        check("async_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("async_no_late_lo", lo, 32'd0);

        // MULTU 0xFFFFFFFF * 2
        issue(3'd1, 32'hFFFFFFFF, 32'd2);
        wait_done(cycles);
        check("multu_cycles", cycles, 32'd5);
        check("multu_hi", hi, 32'd1);
        check("multu_lo", lo, 32'hFFFFFFFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
